rtr_route_filter_reg: RTL and testbench

Registered, packet-aware successor to the combinational route filter for phased-DOR routers. Masks illegal output-port and output-resource-class requests for one input VC, registers the result with 1-cycle latency, and tracks head/tail framing with an IDLE/ACTIVE FSM. Captures sticky error status with a software-style clear, plus optional saturating error counters. Sits between the routing logic and VC allocation on each input VC.

---
 rtl/rtr_route_filter_reg.sv | 192 +++++++++++++++++++
 tb/tb_rtr_route_filter_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rtr_route_filter_reg.sv
// Registered per-VC route filter: masks illegal port/class requests, checks head/tail framing.
// Define RTR_ROUTE_FILTER_ERR_COUNT_EN to add a saturating error-flit counter on err_count.
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 2
`endif
`ifndef DIM_ORDER_ASCENDING
`define DIM_ORDER_ASCENDING 0
`endif
`ifndef DIM_ORDER_DESCENDING
`define DIM_ORDER_DESCENDING 1
`endif
`ifndef DIM_ORDER_BY_CLASS
`define DIM_ORDER_BY_CLASS 2
`endif

module rtr_route_filter_reg #(
  parameter int num_message_classes   = 2,
  parameter int num_resource_classes  = 2,
  parameter int num_vcs_per_class     = 1,
  parameter int num_ports             = 5,
  parameter int num_neighbors_per_dim = 2,
  parameter int num_nodes_per_router  = 1,
  parameter int connectivity          = `CONNECTIVITY_LINE,
  parameter int dim_order             = `DIM_ORDER_ASCENDING,
  parameter int port_id               = 0,
  parameter int vc_id                 = 0,
  parameter int err_count_width       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            route_valid,
  input  logic                            route_head,
  input  logic                            route_tail,
  input  logic [num_ports-1:0]            route_in_op,
  input  logic [num_resource_classes-1:0] route_in_orc,
  input  logic                            err_clear,
  output logic                            route_out_valid,
  output logic [num_ports-1:0]            route_out_op,
  output logic [num_resource_classes-1:0] route_out_orc,
  output logic                            pkt_active,
  output logic [2:0]                      errors,
  output logic [err_count_width-1:0]      err_count
);

  // state  | meaning
  // IDLE   | between packets; next valid flit must be a head
  // ACTIVE | inside a multi-flit packet; body/tail flits expected
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam int message_class  = (vc_id / (num_resource_classes * num_vcs_per_class)) % num_message_classes;
  localparam int resource_class = (vc_id / num_vcs_per_class) % num_resource_classes;
  localparam bit last_rc        = (resource_class == num_resource_classes - 1);
  localparam int num_net_ports  = num_ports - num_nodes_per_router;
  localparam bit port_is_net    = (port_id < num_net_ports);
  localparam bit ascending      = (dim_order == `DIM_ORDER_ASCENDING) ||
                                  ((dim_order == `DIM_ORDER_BY_CLASS) && (message_class % 2 == 0));

  // Once in the last resource class a packet may not turn back or revisit an earlier dimension.
  function automatic logic [num_ports-1:0] calc_port_mask();
    logic [num_ports-1:0] m;
    int port_dim;
    int op_dim;
    m = '1;
    port_dim = port_id / num_neighbors_per_dim;
    for (int op = 0; op < num_ports; op++) begin
      op_dim = op / num_neighbors_per_dim;
      if (op < num_net_ports) begin
        if (last_rc) begin
          if ((connectivity == `CONNECTIVITY_FULL) ? (op_dim == port_dim) : (op == port_id))
            m[op] = 1'b0;
          if (port_is_net && (ascending ? (op_dim < port_dim) : (op_dim > port_dim)))
            m[op] = 1'b0;
        end
      end else if (op == port_id) begin
        m[op] = 1'b0;
      end
    end
    return m;
  endfunction

  function automatic logic [num_resource_classes-1:0] calc_class_mask();
    logic [num_resource_classes-1:0] m;
    m = '0;
    for (int c = 0; c < num_resource_classes; c++)
      if ((c == resource_class) || (c == resource_class + 1))
        m[c] = 1'b1;
    return m;
  endfunction

  localparam logic [num_ports-1:0] port_mask = calc_port_mask();

  logic                            head_flit;
  logic [num_ports-1:0]            op_next;
  logic [num_resource_classes-1:0] orc_next;
  logic                            port_err;
  logic                            class_err;
  logic                            frame_err;
  logic [2:0]                      new_err;
  logic [0:0]                      state;
  logic [0:0]                      state_next;

  assign head_flit = route_valid & route_head;
  assign op_next   = head_flit ? (route_in_op & port_mask) : '0;
  assign port_err  = head_flit & ((|(route_in_op & ~port_mask)) | ~(|route_in_op));

  generate
    if (num_resource_classes == 1) begin : g_single_rc
      logic unused_orc;
      assign unused_orc = ^route_in_orc;
      assign orc_next   = head_flit;
      assign class_err  = 1'b0;
    end else begin : g_multi_rc
      localparam logic [num_resource_classes-1:0] class_mask = calc_class_mask();
      assign orc_next  = head_flit ? (route_in_orc & class_mask) : '0;
      assign class_err = head_flit & ((|(route_in_orc & ~class_mask)) | ~(|route_in_orc));
    end
  endgenerate

  always_comb begin
    state_next = state;
    frame_err  = 1'b0;
    if (route_valid) begin
      case (state)
        IDLE: begin
          if (!route_head)
            frame_err = 1'b1;
          else if (!route_tail)
            state_next = ACTIVE;
        end
        ACTIVE: begin
          // A stray head is flagged but still starts a fresh packet.
          if (route_head) begin
            frame_err  = 1'b1;
            state_next = route_tail ? IDLE : ACTIVE;
          end else if (route_tail) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign new_err = {frame_err, class_err, port_err};

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      route_out_valid <= 1'b0;
      route_out_op    <= '0;
      route_out_orc   <= '0;
      errors          <= 3'b000;
    end else begin
      state           <= state_next;
      route_out_valid <= route_valid;
      route_out_op    <= op_next;
      route_out_orc   <= orc_next;
      errors          <= (err_clear ? 3'b000 : errors) | new_err;
    end
  end

  assign pkt_active = (state == ACTIVE);

`ifdef RTR_ROUTE_FILTER_ERR_COUNT_EN
  localparam logic [err_count_width-1:0] cnt_one = 1;
  logic [err_count_width-1:0] err_cnt_q;
  logic [err_count_width-1:0] cnt_base;

  assign cnt_base = err_clear ? '0 : err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_q <= '0;
    else if ((|new_err) && (cnt_base != '1))
      err_cnt_q <= cnt_base + cnt_one;
    else
      err_cnt_q <= cnt_base;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_rtr_route_filter_reg.sv
// Scoreboard bench for rtr_route_filter_reg: five configurations share one random flit stream.
module tb_rtr_route_filter_reg;

  typedef struct packed {
    logic       v;
    logic [4:0] op;
    logic [1:0] orc;
    logic [2:0] err;
    logic       act;
    logic [7:0] cnt;
  } exp_t;

  // Config per instance; index 4 is the single-resource-class build.
  localparam int VC   [4] = '{1, 3, 1, 0};
  localparam int PID  [4] = '{0, 0, 2, 0};
  localparam int CONN [4] = '{0, 2, 1, 0};
  localparam int DORD [4] = '{0, 2, 0, 0};
  localparam int CW   [4] = '{2, 8, 8, 8};
  // Allowed-port and allowed-class masks worked out by hand from the routing rules.
  localparam logic [4:0] PM [5] = '{5'b11110, 5'b10000, 5'b11000, 5'b11111, 5'b01111};
  localparam logic [1:0] CM [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
  localparam int CMAX [5] = '{3, 255, 255, 255, 255};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       route_valid = 1'b0;
  logic       route_head = 1'b0;
  logic       route_tail = 1'b0;
  logic [4:0] route_in_op = '0;
  logic [1:0] route_in_orc = '0;
  logic       err_clear = 1'b0;

  logic       ov   [5];
  logic [4:0] oop  [5];
  logic [1:0] oorc [5];
  logic [2:0] oerr [5];
  logic       oact [5];
  logic [7:0] ocnt [5];
  logic       orc4;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [CW[g]-1:0] cnt_o;
    rtr_route_filter_reg #(
      .num_resource_classes(2),
      .connectivity(CONN[g]),
      .dim_order(DORD[g]),
      .port_id(PID[g]),
      .vc_id(VC[g]),
      .err_count_width(CW[g])
    ) u_dut (
      .clk(clk), .reset(reset), .route_valid(route_valid), .route_head(route_head),
      .route_tail(route_tail), .route_in_op(route_in_op), .route_in_orc(route_in_orc),
      .err_clear(err_clear), .route_out_valid(ov[g]), .route_out_op(oop[g]),
      .route_out_orc(oorc[g]), .pkt_active(oact[g]), .errors(oerr[g]), .err_count(cnt_o)
    );
    assign ocnt[g] = 8'(cnt_o);
  end

  rtr_route_filter_reg #(
    .num_resource_classes(1),
    .connectivity(1),
    .dim_order(0),
    .port_id(4),
    .vc_id(0),
    .err_count_width(8)
  ) u_dut_rc1 (
    .clk(clk), .reset(reset), .route_valid(route_valid), .route_head(route_head),
    .route_tail(route_tail), .route_in_op(route_in_op), .route_in_orc(route_in_orc[0]),
    .err_clear(err_clear), .route_out_valid(ov[4]), .route_out_op(oop[4]),
    .route_out_orc(orc4), .pkt_active(oact[4]), .errors(oerr[4]), .err_count(ocnt[4])
  );
  assign oorc[4] = {1'b0, orc4};

  exp_t q [5][$];
  logic m_act [5];
  logic [2:0] m_err [5];
  int m_cnt [5];
  int n_checks = 0;
  int n_pass = 0;

  task automatic model_step(input int i, input logic rst, input logic v, input logic h,
                            input logic t, input logic [4:0] op, input logic [1:0] orc,
                            input logic clr);
    exp_t e;
    logic hd;
    logic [2:0] ne;
    int base;
    e = '0;
    ne = '0;
    if (rst) begin
      m_act[i] = 1'b0;
      m_err[i] = 3'b000;
      m_cnt[i] = 0;
    end else begin
      hd = v & h;
      e.v = v;
      e.op = hd ? (op & PM[i]) : 5'b0;
      if (i == 4) e.orc = {1'b0, hd};
      else        e.orc = hd ? (orc & CM[i]) : 2'b0;
      ne[0] = hd && (((op & ~PM[i]) != 5'b0) || (op == 5'b0));
      ne[1] = (i != 4) && hd && (((orc & ~CM[i]) != 2'b0) || (orc == 2'b0));
      ne[2] = v && (m_act[i] ? h : !h);
      if (v && h)      m_act[i] = !t;
      else if (v && t) m_act[i] = 1'b0;
      m_err[i] = (clr ? 3'b000 : m_err[i]) | ne;
      base = clr ? 0 : m_cnt[i];
      if ((ne != 3'b000) && (base < CMAX[i])) base++;
      m_cnt[i] = base;
    end
    e.err = m_err[i];
    e.act = m_act[i];
`ifdef RTR_ROUTE_FILTER_ERR_COUNT_EN
    e.cnt = 8'(m_cnt[i]);
`else
    e.cnt = 8'd0;
`endif
    q[i].push_back(e);
  endtask

  task automatic apply(input logic rst, input logic v, input logic h, input logic t,
                       input logic [4:0] op, input logic [1:0] orc, input logic clr);
    @(negedge clk);
    reset = rst;
    route_valid = v;
    route_head = h;
    route_tail = t;
    route_in_op = op;
    route_in_orc = orc;
    err_clear = clr;
    for (int i = 0; i < 5; i++) model_step(i, rst, v, h, t, op, orc, clr);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 5; i++) s += q[i].size();
    return s;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        exp_t e;
        exp_t g;
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          g = {ov[i], oop[i], oorc[i], oerr[i], oact[i], ocnt[i]};
          n_checks++;
          if (g === e) n_pass++;
          else $display("FAIL dut%0d @%0t: got v=%b op=%b orc=%b err=%b act=%b cnt=%0d, expected v=%b op=%b orc=%b err=%b act=%b cnt=%0d",
                        i, $time, g.v, g.op, g.orc, g.err, g.act, g.cnt,
                        e.v, e.op, e.orc, e.err, e.act, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [4:0] rop;
    int sel;
    apply(1, 0, 0, 0, 5'b0, 2'b0, 0);
    apply(1, 0, 0, 0, 5'b0, 2'b0, 0);
    apply(0, 1, 1, 1, 5'b00001, 2'b10, 0);
    apply(0, 0, 0, 0, 5'b0, 2'b0, 1);
    apply(0, 1, 1, 0, 5'b00100, 2'b10, 0);
    apply(0, 1, 0, 0, 5'b00100, 2'b10, 0);
    apply(0, 1, 0, 1, 5'b0, 2'b0, 0);
    apply(0, 1, 0, 0, 5'b00010, 2'b01, 0);
    apply(0, 0, 0, 0, 5'b0, 2'b0, 1);
    apply(0, 0, 0, 0, 5'b0, 2'b0, 0);
    apply(0, 1, 1, 0, 5'b01000, 2'b11, 0);
    apply(0, 1, 1, 0, 5'b01000, 2'b10, 0);
    apply(1, 0, 0, 0, 5'b0, 2'b0, 0);
    apply(0, 1, 1, 0, 5'b10000, 2'b10, 0);
    apply(1, 0, 0, 0, 5'b0, 2'b0, 0);
    apply(0, 1, 0, 0, 5'b10000, 2'b10, 0);
    apply(0, 0, 0, 0, 5'b0, 2'b0, 1);
    repeat (5) apply(0, 1, 1, 1, 5'b00000, 2'b00, 0);
    apply(0, 1, 1, 1, 5'b00000, 2'b00, 1);
    apply(0, 0, 0, 0, 5'b0, 2'b0, 1);
    apply(0, 1, 1, 1, 5'b11111, 2'b01, 0);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      rop = 5'b0;
      else if (sel < 4)  rop = 5'b1 << $urandom_range(0, 4);
      else               rop = 5'($urandom);
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            rop, 2'($urandom), ($urandom_range(0, 9) == 0));
    end
    apply(0, 0, 0, 0, 5'b0, 2'b0, 0);

    for (int k = 0; k < 10 && pending() > 0; k++) @(posedge clk);
    #2;
    if (pending() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still queued, expected 0", pending());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
